calc_entry_seq: RTL

- Keystroke-driven sequencer for the calculator datapath.
- Consumes decoded key events from the keyboard controller and assembles two packed-BCD operands and an operator.
- Presents them to the ALU, waits out the ALU latency, captures the result, and drives the value shown on the 4-digit display (via the bin/BCD display path).
- Sits between the keyboard controller, the ALU and the display driver.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/bcd_entry_reg.sv | 68 ++++++
 rtl/calc_entry_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, ALU operator codes and sequencer state encoding for the calculator.
package calc_pkg;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_CLR = 4'hD;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_BS  = 4'hF;

   // ALU operator codes reuse the key encoding so operator keys pass straight through.
   localparam logic [3:0] OP_ADD = KEY_ADD;
   localparam logic [3:0] OP_SUB = KEY_SUB;
   localparam logic [3:0] OP_MUL = KEY_MUL;

   typedef enum logic [1:0] {
      ENT_A = 2'd0,
      ENT_B = 2'd1,
      EXEC  = 2'd2,
      SHOW  = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k == OP_ADD) || (k == OP_SUB) || (k == OP_MUL);
   endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Packed-BCD operand shift register with digit counter: clear > load > push > backspace.
// Exposes next-state values so the owner can register a display copy in the same edge.
module bcd_entry_reg #(
   parameter int unsigned NDIG = 4,
   parameter int unsigned CW   = $clog2(NDIG + 1)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 clr,
   input  logic                 load,
   input  logic [4*NDIG-1:0]    load_val,
   input  logic [CW-1:0]        load_cnt,
   input  logic                 push,
   input  logic [3:0]           digit,
   input  logic                 bs,
   output logic [4*NDIG-1:0]    value,
   output logic [CW-1:0]        cnt,
   output logic [4*NDIG-1:0]    nxt_value,
   output logic [CW-1:0]        nxt_cnt
);

   localparam int unsigned W = 4 * NDIG;
   localparam logic [CW-1:0] FULL = CW'(NDIG);

   logic [W-1:0]  r_val;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  w_val_nxt;
   logic [CW-1:0] w_cnt_nxt;

   always_comb begin
      w_val_nxt = r_val;
      w_cnt_nxt = r_cnt;
      if (clr) begin
         w_val_nxt = '0;
         w_cnt_nxt = '0;
      end else if (load) begin
         w_val_nxt = load_val;
         w_cnt_nxt = load_cnt;
      end else if (push) begin
         // A leading zero shifts in but does not consume a digit slot.
         if (r_cnt != FULL) begin
            w_val_nxt = {r_val[W-5:0], digit};
            if (!(r_cnt == '0 && digit == 4'h0))
               w_cnt_nxt = r_cnt + CW'(1);
         end
      end else if (bs) begin
         w_val_nxt = {4'h0, r_val[W-1:4]};
         if (r_cnt != '0)
            w_cnt_nxt = r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_val <= '0;
         r_cnt <= '0;
      end else begin
         r_val <= w_val_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign value     = r_val;
   assign cnt       = r_cnt;
   assign nxt_value = w_val_nxt;
   assign nxt_cnt   = w_cnt_nxt;

endmodule

// File: rtl/calc_entry_seq.sv
// Keystroke sequencer: builds two BCD operands and an operator, runs the ALU, shows the result.
// Optional macro CALC_CHAIN_EN: an operator key in SHOW chains the result into a new operation.
module calc_entry_seq
   import calc_pkg::*;
#(
   parameter int unsigned NDIG    = 4,
   parameter int unsigned ALU_LAT = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 key_valid,
   input  logic [3:0]           key_code,
   input  logic [4*NDIG-1:0]    alu_res,
   input  logic                 alu_err,
   output logic [4*NDIG-1:0]    alu_num1,
   output logic [4*NDIG-1:0]    alu_num2,
   output logic [3:0]           alu_op,
   output logic [4*NDIG-1:0]    disp_value,
   output logic                 disp_err,
   output logic                 busy
);

   localparam int unsigned W  = 4 * NDIG;
   localparam int unsigned CW = $clog2(NDIG + 1);
   localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

   state_t        r_state;
   logic [3:0]    r_op;
   logic [3:0]    r_lat;
   logic [W-1:0]  r_disp;
   logic          r_err;
   logic          r_busy;

   logic          w_dig, w_op, w_clr, w_eq, w_bs;
   logic          w_a_clr, w_a_load, w_a_push, w_a_bs;
   logic [W-1:0]  w_a_load_val;
   logic [CW-1:0] w_a_load_cnt;
   logic          w_b_clr, w_b_push, w_b_bs;
   logic [W-1:0]  w_a_val, w_a_nxt, w_b_val, w_b_nxt;
   logic [CW-1:0] w_a_cnt, w_a_cnt_nxt, w_b_cnt, w_b_cnt_nxt;
   logic          w_unused;

   assign w_dig = key_valid && is_digit(key_code);
   assign w_op  = key_valid && is_op(key_code);
   assign w_clr = key_valid && (key_code == KEY_CLR) && (r_state != EXEC);
   assign w_eq  = key_valid && (key_code == KEY_EQ);
   assign w_bs  = key_valid && (key_code == KEY_BS);

   always_comb begin
      w_a_clr      = 1'b0;
      w_a_load     = 1'b0;
      w_a_push     = 1'b0;
      w_a_bs       = 1'b0;
      w_a_load_val = '0;
      w_a_load_cnt = '0;
      w_b_clr      = 1'b0;
      w_b_push     = 1'b0;
      w_b_bs       = 1'b0;
      if (w_clr) begin
         w_a_clr = 1'b1;
         w_b_clr = 1'b1;
      end else begin
         case (r_state)
            ENT_A: begin
               w_a_push = w_dig;
               w_a_bs   = w_bs;
               w_b_clr  = w_op;
            end
            ENT_B: begin
               w_b_push = w_dig;
               w_b_bs   = w_bs;
            end
            EXEC: begin
               if (r_lat == '0) begin
                  w_a_load     = 1'b1;
                  w_a_load_val = alu_res;
               end
            end
            SHOW: begin
               w_a_load     = w_dig;
               w_a_load_val = W'(key_code);
               w_a_load_cnt = CW'(1);
`ifdef CALC_CHAIN_EN
               w_b_clr      = w_op && !r_err;
`endif
            end
            default: ;
         endcase
      end
   end

   bcd_entry_reg #(.NDIG(NDIG)) u_opa (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (w_a_clr),
      .load      (w_a_load),
      .load_val  (w_a_load_val),
      .load_cnt  (w_a_load_cnt),
      .push      (w_a_push),
      .digit     (key_code),
      .bs        (w_a_bs),
      .value     (w_a_val),
      .cnt       (w_a_cnt),
      .nxt_value (w_a_nxt),
      .nxt_cnt   (w_a_cnt_nxt)
   );

   bcd_entry_reg #(.NDIG(NDIG)) u_opb (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (w_b_clr),
      .load      (1'b0),
      .load_val  ('0),
      .load_cnt  ('0),
      .push      (w_b_push),
      .digit     (key_code),
      .bs        (w_b_bs),
      .value     (w_b_val),
      .cnt       (w_b_cnt),
      .nxt_value (w_b_nxt),
      .nxt_cnt   (w_b_cnt_nxt)
   );

   assign w_unused = &{1'b0, w_a_cnt, w_a_cnt_nxt};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ENT_A;
         r_op    <= '0;
         r_lat   <= '0;
         r_disp  <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else if (w_clr) begin
         r_state <= ENT_A;
         r_op    <= '0;
         r_lat   <= '0;
         r_disp  <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ENT_A: begin
               if (w_dig || w_bs) begin
                  r_disp <= w_a_nxt;
               end else if (w_op) begin
                  r_op    <= key_code;
                  r_disp  <= w_a_val;
                  r_state <= ENT_B;
               end
            end
            ENT_B: begin
               // Until a B digit exists the display keeps showing A.
               if (w_dig || w_bs) begin
                  r_disp <= (w_b_cnt_nxt == '0) ? w_a_val : w_b_nxt;
               end else if (w_op) begin
                  if (w_b_cnt == '0)
                     r_op <= key_code;
               end else if (w_eq) begin
                  r_lat   <= LAT_INIT;
                  r_busy  <= 1'b1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (r_lat == '0) begin
                  r_disp  <= alu_res;
                  r_err   <= alu_err;
                  r_busy  <= 1'b0;
                  r_state <= SHOW;
               end else begin
                  r_lat <= r_lat - 4'd1;
               end
            end
            SHOW: begin
               if (w_dig) begin
                  r_disp  <= W'(key_code);
                  r_err   <= 1'b0;
                  r_state <= ENT_A;
               end
`ifdef CALC_CHAIN_EN
               else if (w_op && !r_err) begin
                  r_op    <= key_code;
                  r_state <= ENT_B;
               end
`endif
            end
            default: r_state <= ENT_A;
         endcase
      end
   end

   assign alu_num1   = w_a_val;
   assign alu_num2   = w_b_val;
   assign alu_op     = r_op;
   assign disp_value = r_disp;
   assign disp_err   = r_err;
   assign busy       = r_busy;

endmodule
